// File: rtl/sine_phase_gen_if.sv
// Bus bundle for sine_phase_gen: sample strobe, start/stop control, tuning
// word in; ROM address/enable, sample-valid, sign, wrap and busy out.
interface sine_phase_gen_if #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6
);
    logic               tick;
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] ftw;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_en;
    logic               sample_valid;
    logic               negate;
    logic               wrap;
    logic               busy;

    // Controller / bench side
    modport master (
        output tick, start, stop, ftw,
        input  rom_addr, rom_en, sample_valid, negate, wrap, busy
    );

    // Generator side
    modport slave (
        input  tick, start, stop, ftw,
        output rom_addr, rom_en, sample_valid, negate, wrap, busy
    );
endinterface

// File: rtl/sine_phase_gen.sv
// sine_phase_gen: phase-accumulator front end for a sine ROM. Each sample
// tick issues a registered ROM read for the current phase and advances the
// phase by the latched tuning word. A stop request lets the current period
// finish (up to the accumulator carry) before returning to idle.
// Build option: define SINE_QUARTER_WAVE_EN to address a quarter-wave table
// (address mirrored in odd quadrants, negate flag set in the second half).
module sine_phase_gen #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sine_phase_gen_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q;
    logic [PHASE_W-1:0]  ftw_l;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_en_q;
    logic                sample_valid_q;
    logic                neg_rd_q;     // sign of the sample currently being read
    logic                negate_q;     // sign aligned with sample_valid
    logic                wrap_q;

    logic                do_load;      // latch ftw, clear phase
    logic                do_step;      // issue ROM read, advance phase
    logic                do_clear;     // drain done, clear phase

    logic [PHASE_W:0]    phase_sum;
    logic [ADDR_W-1:0]   addr_cur;
    logic                neg_cur;

    // Extra top bit of the sum is the accumulator carry-out (period boundary).
    assign phase_sum = {1'b0, phase_q} + {1'b0, ftw_l};

`ifdef SINE_QUARTER_WAVE_EN
    logic [1:0]          quad;
    logic [ADDR_W-1:0]   k;

    assign quad     = phase_q[PHASE_W-1 -: 2];
    assign k        = phase_q[PHASE_W-3 -: ADDR_W];
    // Odd quadrants run the table backwards; the second half is negated.
    assign addr_cur = quad[0] ? ~k : k;
    assign neg_cur  = quad[1];
`else
    assign addr_cur = phase_q[PHASE_W-1 -: ADDR_W];
    assign neg_cur  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath control. In DRAIN the exit takes priority over a
    // coincident tick so nothing is issued on the way out.
    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_step  = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    do_load = 1'b1;
                end
            end
            RUN: begin
                do_step = bus.tick;
                if (bus.stop) state_d = DRAIN;
            end
            DRAIN: begin
                // wrap_q marks the edge after the period-closing tick; a zero
                // tuning word never wraps, so leave straight away.
                if (wrap_q || (ftw_l == '0)) begin
                    state_d  = IDLE;
                    do_clear = 1'b1;
                end else begin
                    do_step = bus.tick;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase accumulator and tuning-word latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            ftw_l   <= '0;
        end else if (do_load) begin
            phase_q <= '0;
            ftw_l   <= bus.ftw;
        end else if (do_clear) begin
            phase_q <= '0;
        end else if (do_step) begin
            phase_q <= phase_sum[PHASE_W-1:0];
        end
    end

    // ROM read stage: address from the pre-add phase, one-cycle enable/wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            wrap_q     <= 1'b0;
            neg_rd_q   <= 1'b0;
        end else begin
            rom_en_q <= do_step;
            wrap_q   <= do_step & phase_sum[PHASE_W];
            if (do_step) begin
                rom_addr_q <= addr_cur;
                neg_rd_q   <= neg_cur;
            end
        end
    end

    // Data stage: valid and sign follow the ROM's one-cycle read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid_q <= 1'b0;
            negate_q       <= 1'b0;
        end else begin
            sample_valid_q <= rom_en_q;
            negate_q       <= neg_rd_q;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_en       = rom_en_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.negate       = negate_q;
    assign bus.wrap         = wrap_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed bench for sine_phase_gen (PHASE_W=16, ADDR_W=6). Inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_sine_phase_gen;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

`ifdef SINE_QUARTER_WAVE_EN
    localparam logic [15:0] STEP_FTW = 16'd256;   // one address per tick in quadrant 0
`else
    localparam logic [15:0] STEP_FTW = 16'd1024;  // one address per tick
`endif

    sine_phase_gen_if #(.PHASE_W(16), .ADDR_W(6)) bus ();

    sine_phase_gen #(.PHASE_W(16), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // One tick; check read stage, then data stage and busy after it.
    task automatic do_tick(input int ea, input bit ew, input bit en, input bit eb);
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        chk("rom_en", bus.rom_en, 1);
        chk("rom_addr", bus.rom_addr, ea);
        chk("wrap", bus.wrap, ew);
        @(negedge clk);
        chk("sample_valid", bus.sample_valid, 1);
        chk("rom_en_off", bus.rom_en, 0);
        chk("wrap_off", bus.wrap, 0);
        chk("negate", bus.negate, en);
        chk("busy", bus.busy, eb);
    endtask

    // Tick that must produce nothing.
    task automatic dead_tick(input string tag);
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        chk({tag, "_rom_en"}, bus.rom_en, 0);
        chk({tag, "_wrap"}, bus.wrap, 0);
        @(negedge clk);
        chk({tag, "_sample_valid"}, bus.sample_valid, 0);
    endtask

    task automatic do_start(input logic [15:0] f);
        @(negedge clk) begin bus.ftw = f; bus.start = 1'b1; end
        @(negedge clk) bus.start = 1'b0;
        chk("busy_start", bus.busy, 1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_addr"}, bus.rom_addr, 0);
        chk({tag, "_rom_en"}, bus.rom_en, 0);
        chk({tag, "_sample_valid"}, bus.sample_valid, 0);
        chk({tag, "_negate"}, bus.negate, 0);
        chk({tag, "_wrap"}, bus.wrap, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ftw   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Ticks and stop in IDLE do nothing
        @(negedge clk) bus.stop = 1'b1;
        @(negedge clk) bus.stop = 1'b0;
        chk("idle_stop_busy", bus.busy, 0);
        dead_tick("idle");
        chk("idle_busy", bus.busy, 0);

`ifdef SINE_QUARTER_WAVE_EN
        // Quarter wave: 0..63, 63..0 positive, then the same negated; wrap at 256th tick
        do_start(16'd256);
        for (int i = 0; i < 257; i++) begin
            int q;
            int k;
            q = (i % 256) / 64;
            k = i % 64;
            do_tick((q % 2) ? 63 - k : k, i == 255, q >= 2, 1);
        end
        do_reset();
`else
        // ftw=1024 (start+stop together in IDLE acts as start): 0..63,0, wrap on 64th
        @(negedge clk) begin bus.ftw = 16'd1024; bus.start = 1'b1; bus.stop = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.stop = 1'b0; end
        chk("busy_start_stop", bus.busy, 1);
        for (int i = 0; i < 65; i++) do_tick(i % 64, i == 63, 0, 1);
        for (int i = 1; i <= 10; i++) do_tick(i, 0, 0, 1);

        // stop (with start) after address 10: drain to 63, idle one edge after wrap
        @(negedge clk) begin bus.stop = 1'b1; bus.start = 1'b1; end
        @(negedge clk) begin bus.stop = 1'b0; bus.start = 1'b0; end
        chk("drain_busy", bus.busy, 1);
        for (int i = 11; i <= 63; i++) do_tick(i, i == 63, 0, i != 63);
        dead_tick("after_drain");
        chk("after_drain_busy", bus.busy, 0);

        // ftw=2048, later ftw change and start in RUN ignored: 0,2,..,62,0
        do_start(16'd2048);
        @(negedge clk) begin bus.ftw = 16'd4096; bus.start = 1'b1; end
        @(negedge clk) bus.start = 1'b0;
        for (int i = 0; i < 33; i++) do_tick((2 * i) % 64, i == 31, 0, 1);
        for (int i = 1; i <= 31; i++) do_tick(2 * i, i == 31, 0, 1);
        do_reset();
`endif

        // Reset mid-RUN at address 20 while rom_en is high
        do_start(STEP_FTW);
        for (int i = 0; i < 20; i++) do_tick(i, 0, 0, 1);
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        chk("pre_rst_addr", bus.rom_addr, 20);
        chk("pre_rst_en", bus.rom_en, 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dead_tick("post_rst");
        chk("post_rst_busy", bus.busy, 0);
        do_start(STEP_FTW);
        do_tick(0, 0, 0, 1);
        do_tick(1, 0, 0, 1);
        do_reset();

        // ftw=0: address 0 five times, no wrap; stop exits within 2 clk
        do_start(16'd0);
        for (int i = 0; i < 5; i++) do_tick(0, 0, 0, 1);
        @(negedge clk) bus.stop = 1'b1;
        @(negedge clk) bus.stop = 1'b0;
        @(negedge clk);
        chk("ftw0_stop_busy", bus.busy, 0);
        dead_tick("ftw0_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Cycle budget guard
    initial begin
        #900000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
